// File: rtl/upa1_stage.sv
// rtl/upa1_stage.sv - G.726 UPA1 first-order pole coefficient update, 2-stage multi-channel pipeline
//
// Computes the unlimited A1T = A1 + (UGA1 - ULA1) from A1, PK0, PK1 and SIGPK.
// The result feeds the A1T input of the downstream LIMD limiter.
// Optional feature macro: UPA1_TRIG_EN. When it is defined, a tr input is added,
// and tr=1 forces the word's a1t to zero.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   in_valid/in_ready     input handshake; in_ch is the channel tag
//   a1, pk0, pk1, sigpk   UPA1 operands
//   a2p_pass              A2P value that travels with the word
//   tr                    trigger reset (only with UPA1_TRIG_EN)
//   out_valid/out_ready   output handshake; out_ch is the tag of the output word
//   a1t, a2p_out          result and the aligned A2P
//   scan_*, test_mode     DFT hooks; scan outputs are tied low until scan insertion
module upa1_stage #(
    parameter int CH_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH_W-1:0] in_ch,
    input  logic [15:0]     a1,
    input  logic            pk0,
    input  logic            pk1,
    input  logic            sigpk,
`ifdef UPA1_TRIG_EN
    input  logic            tr,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH_W-1:0] out_ch,
    output logic [15:0]     a1t,
    input  logic [15:0]     a2p_pass,
    output logic [15:0]     a2p_out,
    input  logic            scan_in0,
    input  logic            scan_in1,
    input  logic            scan_in2,
    input  logic            scan_in3,
    input  logic            scan_in4,
    input  logic            scan_enable,
    input  logic            test_mode,
    output logic            scan_out0,
    output logic            scan_out1,
    output logic            scan_out2,
    output logic            scan_out3,
    output logic            scan_out4
);

    logic            s1_valid;
    logic [15:0]     s1_uga1;
    logic [15:0]     s1_ula1;
    logic [15:0]     s1_a1;
    logic [CH_W-1:0] s1_ch;
    logic [15:0]     s1_a2p;
`ifdef UPA1_TRIG_EN
    logic            s1_tr;
`endif

    logic            s2_adv;
    logic            s1_adv;
    logic [15:0]     uga1;
    logic [15:0]     ula1;
    logic [15:0]     a1t_calc;
    logic [15:0]     a1t_next;

    // Scan chains are stitched later; the hooks are deliberately unused here.
    logic dft_unused;
    assign dft_unused = &{1'b0, scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                          scan_enable, test_mode};
    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;

    // out_ready -> in_ready is the only combinational path through the block.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv && reset;

    // Gain term: +192 when the PK signs agree, -192 when they differ, 0 for a zero estimate.
    assign uga1 = sigpk ? 16'h0000 : ((pk0 ^ pk1) ? 16'hFF40 : 16'h00C0);
    // Leak term: A1 arithmetically shifted right by 8.
    assign ula1 = {{8{a1[15]}}, a1[15:8]};

    // Plain modulo-2^16 sum; limiting is left to LIMD.
    assign a1t_calc = s1_a1 + (s1_uga1 - s1_ula1);
`ifdef UPA1_TRIG_EN
    assign a1t_next = s1_tr ? 16'h0000 : a1t_calc;
`else
    assign a1t_next = a1t_calc;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_uga1   <= '0;
            s1_ula1   <= '0;
            s1_a1     <= '0;
            s1_ch     <= '0;
            s1_a2p    <= '0;
`ifdef UPA1_TRIG_EN
            s1_tr     <= 1'b0;
`endif
            out_valid <= 1'b0;
            a1t       <= '0;
            out_ch    <= '0;
            a2p_out   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_uga1 <= uga1;
                    s1_ula1 <= ula1;
                    s1_a1   <= a1;
                    s1_ch   <= in_ch;
                    s1_a2p  <= a2p_pass;
`ifdef UPA1_TRIG_EN
                    s1_tr   <= tr;
`endif
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    a1t     <= a1t_next;
                    out_ch  <= s1_ch;
                    a2p_out <= s1_a2p;
                end
            end
        end
    end

endmodule

// File: tb/tb_upa1_stage.sv
// tb/tb_upa1_stage.sv - scoreboard testbench for upa1_stage
module tb_upa1_stage;
    localparam int CH_W = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [CH_W-1:0] in_ch = '0;
    logic [15:0]     a1 = '0;
    logic            pk0 = 1'b0, pk1 = 1'b0, sigpk = 1'b0;
    logic            tr = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [CH_W-1:0] out_ch;
    logic [15:0]     a1t;
    logic [15:0]     a2p_pass = '0;
    logic [15:0]     a2p_out;
    logic            so0, so1, so2, so3, so4;

    upa1_stage #(.CH_W(CH_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .a1(a1), .pk0(pk0), .pk1(pk1), .sigpk(sigpk),
`ifdef UPA1_TRIG_EN
        .tr(tr),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .a1t(a1t), .a2p_pass(a2p_pass), .a2p_out(a2p_out),
        .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0),
        .scan_in4(1'b0), .scan_enable(1'b0), .test_mode(1'b0),
        .scan_out0(so0), .scan_out1(so1), .scan_out2(so2), .scan_out3(so3),
        .scan_out4(so4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     a1t;
        logic [CH_W-1:0] ch;
        logic [15:0]     a2p;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   stream_mode = 1'b0;
    int   pop_cycles[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: G.726 UPA1 with integer arithmetic, floor division for the shift.
    function automatic logic [15:0] ref_a1t(input logic [15:0] a1v, input bit p0, input bit p1,
                                            input bit sp, input bit trv);
        int a, g, l, r;
        if (trv) return 16'h0000;
        a = int'($signed(a1v));
        g = sp ? 0 : ((p0 != p1) ? -192 : 192);
        l = (a >= 0) ? a / 256 : -((-a + 255) / 256);
        r = a + g - l;
        return r[15:0];
    endfunction

    // Monitor: compares every accepted output and checks stalled outputs hold steady.
    exp_t held;
    bit   hold_pending = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset && hold_pending) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_a1t", {16'd0, a1t}, {16'd0, held.a1t});
            check("hold_ch", {27'd0, out_ch}, {27'd0, held.ch});
        end
        hold_pending = reset && out_valid && !out_ready;
        held.a1t = a1t; held.ch = out_ch; held.a2p = a2p_out;
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got ch %0d a1t %0h, expected no output", out_ch, a1t);
            end else begin
                e = exp_q.pop_front();
                check("out_a1t", {16'd0, a1t}, {16'd0, e.a1t});
                check("out_ch", {27'd0, out_ch}, {27'd0, e.ch});
                check("out_a2p", {16'd0, a2p_out}, {16'd0, e.a2p});
                if (stream_mode) pop_cycles.push_back(cyc);
            end
        end
    end

    // Called just after a rising edge; drives a word and records its expected result.
    task automatic present(input logic [CH_W-1:0] ch, input logic [15:0] a1v, input bit p0,
                           input bit p1, input bit sp, input bit trv, input logic [15:0] a2,
                           input int expv);
        in_ch = ch; a1 = a1v; pk0 = p0; pk1 = p1; sigpk = sp; tr = trv; a2p_pass = a2;
        in_valid = 1'b1;
        pend.a1t = (expv < 0) ? ref_a1t(a1v, p0, p1, sp, trv) : expv[15:0];
        pend.ch  = ch;
        pend.a2p = a2;
    endtask

    task automatic wait_accept(output int waits);
        bit acc;
        waits = 0;
        acc = 1'b0;
        while (!acc && waits < 1000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            waits++;
        end
        if (acc) exp_q.push_back(pend);
        else begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept", waits);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [CH_W-1:0] ch, input logic [15:0] a1v, input bit p0,
                        input bit p1, input bit sp, input bit trv, input logic [15:0] a2,
                        input int expv, output int waits);
        present(ch, a1v, p0, p1, sp, trv, a2, expv);
        wait_accept(waits);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    int  w;
    bit  rand_done;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_a1t", {16'd0, a1t}, 0);
        check("rst_out_ch", {27'd0, out_ch}, 0);
        check("rst_a2p", {16'd0, a2p_out}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        out_ready = 1'b1;

        // First word with latency check
        send(5'd0, 16'h0000, 0, 0, 0, 0, 16'h1234, 16'h00C0, w);
        @(negedge clk);
        check("lat_cycle1", {31'd0, out_valid}, 0);
        @(negedge clk);
        check("lat_cycle2", {31'd0, out_valid}, 1);
        @(posedge clk); #1;

        // Stall: two accepted, third blocked while outputs hold
        out_ready = 1'b0;
        send(5'd1, 16'h1000, 1, 0, 0, 0, 16'hA001, 16'h0F30, w);
        send(5'd2, 16'hE000, 0, 0, 1, 0, 16'hA002, 16'hE020, w);
        present(5'd3, 16'h7FF0, 0, 0, 0, 0, 16'hA003, 16'h8031);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 0);
            check("stall_out_ch", {27'd0, out_ch}, 1);
            check("stall_a1t", {16'd0, a1t}, 32'h0F30);
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        wait_accept(w);
        drain();

        // Continuous stream, one word per cycle
        @(posedge clk); #1;
        stream_mode = 1'b1;
        for (int i = 0; i < 32; i++) begin
            send(i[CH_W-1:0], 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0,
                 16'($urandom), -1, w);
            check("stream_no_wait", w, 1);
        end
        drain();
        repeat (2) @(posedge clk);
        stream_mode = 1'b0;
        check("stream_count", pop_cycles.size(), 32);
        if (pop_cycles.size() == 32)
            check("stream_back_to_back", pop_cycles[31] - pop_cycles[0], 31);
        #1;

        // Reset with two words in flight
        send(5'd7, 16'h4000, 0, 1, 0, 0, 16'h0007, -1, w);
        send(5'd8, 16'hC000, 1, 1, 0, 0, 16'h0008, -1, w);
        out_ready = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_in_ready", {31'd0, in_ready}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 0);
        check("midrst_a1t", {16'd0, a1t}, 0);
        check("midrst_out_ch", {27'd0, out_ch}, 0);
        check("midrst_a2p", {16'd0, a2p_out}, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_silent", {31'd0, out_valid}, 0);
        end
        @(posedge clk); #1;
        send(5'd9, 16'h1000, 1, 0, 0, 0, 16'h0009, 16'h0F30, w);
        @(negedge clk);
        check("postrst_lat1", {31'd0, out_valid}, 0);
        @(negedge clk);
        check("postrst_lat2", {31'd0, out_valid}, 1);
        @(posedge clk); #1;

`ifdef UPA1_TRIG_EN
        send(5'd10, 16'h1000, 1, 0, 0, 1, 16'h000A, 16'h0000, w);
        send(5'd11, 16'h1000, 1, 0, 0, 0, 16'h000B, 16'h0F30, w);
        drain();
        @(posedge clk); #1;
`endif

        // Random words under random backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
`ifdef UPA1_TRIG_EN
                    send(CH_W'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                         ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                         16'($urandom), -1, w);
`else
                    send(CH_W'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                         ($urandom_range(0, 3) == 0), 0, 16'($urandom), -1, w);
`endif
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
